// File: rtl/div_share_sched_if.sv
// Requester-side bundle for the shared divider: level requests, operand buses,
// and the grant/done/result signals returned to the winning requester.
interface div_share_sched_if #(
    parameter int W    = 10,
    parameter int FRAC = 8
);
    logic [2:0]      req;
    logic [3*W-1:0]  dividend_bus;
    logic [3*W-1:0]  divisor_bus;
    logic [2:0]      grant;
    logic [2:0]      done;
    logic            busy;
    logic [W-1:0]    quotient;
    logic [FRAC-1:0] fractional;
    logic            div_by_zero;

    modport master (
        output req, dividend_bus, divisor_bus,
        input  grant, done, busy, quotient, fractional, div_by_zero
    );

    modport slave (
        input  req, dividend_bus, divisor_bus,
        output grant, done, busy, quotient, fractional, div_by_zero
    );
endinterface

// File: rtl/div_share_sched.sv
// Round-robin scheduler around one shared restoring divider producing
// floor(dividend * 2^FRAC / divisor) for three HSV-path requesters.
module div_share_sched #(
    parameter int W    = 10,
    parameter int FRAC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    div_share_sched_if.slave bus
);
    localparam int N  = W + FRAC;
    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      win_q, win_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [N-1:0]    bits_q, bits_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      done_q, done_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    quotient_q, quotient_d;
    logic [FRAC-1:0] fractional_q, fractional_d;
    logic            div_by_zero_q, div_by_zero_d;

    logic [1:0]      pick;
    logic            pick_vld;
    logic [1:0]      idx;
    logic [W-1:0]    cap_divisor;
    logic [W+1:0]    rem_sh;
    logic            rem_ge;

    // Round-robin: the lowest offset from last+1 wins, so scan offsets downward.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last_q) + k) % 3);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // The shifted remainder can reach 2*divisor-1, so the compare is done one bit wider.
    always_comb begin
        rem_sh = {rem_q, bits_q[N-1]};
        rem_ge = (rem_sh >= (W+2)'(divisor_q));
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a
        // signal unassigned; that is what keeps this block free of latches.
        state_d       = state_q;
        last_d        = last_q;
        win_d         = win_q;
        count_d       = count_q;
        rem_d         = rem_q;
        divisor_d     = divisor_q;
        bits_d        = bits_q;
        grant_d       = grant_q;
        done_d        = done_q;
        busy_d        = busy_q;
        quotient_d    = quotient_q;
        fractional_d  = fractional_q;
        div_by_zero_d = div_by_zero_q;
        cap_divisor   = bus.divisor_bus[int'(pick)*W +: W];

        if (ce) begin
            grant_d = 3'b000;
            done_d  = 3'b000;
            case (state_q)
                IDLE: begin
                    // The cycle showing done is skipped so the finishing requester can drop req.
                    if (pick_vld && (done_q == 3'b000)) begin
                        win_d     = pick;
                        divisor_d = cap_divisor;
                        bits_d    = {bus.dividend_bus[int'(pick)*W +: W], {FRAC{1'b0}}};
                        rem_d     = '0;
                        count_d   = '0;
                        grant_d   = 3'b001 << pick;
                        busy_d    = 1'b1;
                        state_d   = (cap_divisor == '0) ? DONE : ITER;
                    end
                end
                ITER: begin
                    // Quotient bits shift in at the bottom as stream bits leave the top.
                    rem_d   = rem_ge ? (W+1)'(rem_sh - (W+2)'(divisor_q)) : rem_sh[W:0];
                    bits_d  = {bits_q[N-2:0], rem_ge};
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(N-1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 3'b001 << win_q;
                    busy_d  = 1'b0;
                    last_d  = win_q;
                    state_d = IDLE;
                    if (divisor_q == '0) begin
                        quotient_d    = '1;
                        fractional_d  = '1;
                        div_by_zero_d = 1'b1;
                    end else begin
                        quotient_d    = bits_q[N-1:FRAC];
                        fractional_d  = bits_q[FRAC-1:0];
                        div_by_zero_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 2'd2;
            win_q         <= 2'd0;
            count_q       <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            bits_q        <= '0;
            grant_q       <= 3'b000;
            done_q        <= 3'b000;
            busy_q        <= 1'b0;
            quotient_q    <= '0;
            fractional_q  <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            win_q         <= win_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            divisor_q     <= divisor_d;
            bits_q        <= bits_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            quotient_q    <= quotient_d;
            fractional_q  <= fractional_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.quotient    = quotient_q;
    assign bus.fractional  = fractional_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_div_share_sched.sv
// Randomized and directed checks of div_share_sched against a transaction-level
// model: round-robin pick, fixed grant-to-done latency, floor(a*2^FRAC/b).
module tb_div_share_sched;
    localparam int W    = 10;
    localparam int FRAC = 8;
    localparam int LAT  = W + FRAC + 1;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    div_share_sched_if #(.W(W), .FRAC(FRAC)) dif ();
    div_share_sched #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .ce(ce), .bus(dif));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: one in-flight job, a one-edge gap after each done.
    int              m_active, m_cool, m_win, m_n, m_lat, m_last;
    logic [W-1:0]    m_a, m_b;
    logic [2:0]      e_grant, e_done;
    logic            e_busy, e_dz;
    logic [W-1:0]    e_q;
    logic [FRAC-1:0] e_f;

    bit              log_en = 1'b0;
    logic [2:0]      glog[$];
    int              rq[3];
    int              rf[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_cool = 0; m_last = 2; m_win = 0; m_n = 0; m_lat = 0;
        e_grant = '0; e_done = '0; e_busy = 1'b0;
        e_q = '0; e_f = '0; e_dz = 1'b0;
    endtask

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++)
            if (r[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    task automatic model_edge();
        longint unsigned r;
        int w;
        if (!ce) return;
        e_grant = '0;
        e_done  = '0;
        if (m_active != 0) begin
            m_n++;
            if (m_n == m_lat) begin
                e_done = 3'(1 << m_win);
                if (m_b == 0) begin
                    e_q = '1; e_f = '1; e_dz = 1'b1;
                end else begin
                    r    = (longint'(m_a) << FRAC) / longint'(m_b);
                    e_q  = W'(r >> FRAC);
                    e_f  = FRAC'(r);
                    e_dz = 1'b0;
                end
                m_last = m_win; m_active = 0; m_cool = 1; e_busy = 1'b0;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else begin
            w = rr_pick(dif.req, m_last);
            if (w >= 0) begin
                m_win    = w;
                m_a      = dif.dividend_bus[w*W +: W];
                m_b      = dif.divisor_bus[w*W +: W];
                m_lat    = (m_b == 0) ? 1 : LAT;
                m_n      = 0;
                m_active = 1;
                e_grant  = 3'(1 << w);
                e_busy   = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("grant", dif.grant, e_grant);
        check("done", dif.done, e_done);
        check("busy", dif.busy, e_busy);
        check("quotient", dif.quotient, e_q);
        check("fractional", dif.fractional, e_f);
        check("div_by_zero", dif.div_by_zero, e_dz);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (log_en && dif.grant != 3'b000) glog.push_back(dif.grant);
        for (int i = 0; i < 3; i++)
            if (dif.done[i]) begin
                rq[i] = int'(dif.quotient);
                rf[i] = int'(dif.fractional);
            end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        dif.dividend_bus[i*W +: W] = W'(a);
        dif.divisor_bus[i*W +: W]  = W'(b);
    endtask

    // kind 0 waits for grant[i], kind 1 for done[i]
    task automatic wait_for(input int kind, input int i);
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            tick();
            if (kind == 0 ? dif.grant[i] : dif.done[i]) ok = 1'b1;
        end
        check(kind == 0 ? "wait_grant" : "wait_done", ok, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_done", dif.done, 0);
        rst = 1'b0;
    endtask

    task automatic single(input int i, input int a, input int b, input bit stall,
                          input int eq, input int ef, input int edz);
        int lat = 0;
        bit started = 1'b0;
        bit seen = 1'b0;
        bit c;
        set_ops(i, a, b);
        dif.req[i] = 1'b1;
        for (int t = 0; t < 400 && !seen; t++) begin
            ce = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            c  = ce;
            tick();
            if (started && c) lat++;
            if (!started && dif.grant[i]) started = 1'b1;
            if (dif.done[i]) seen = 1'b1;
        end
        dif.req[i] = 1'b0;
        check("done_seen", seen, 1);
        check("latency", lat, (b == 0) ? 1 : LAT);
        check("q_lit", dif.quotient, eq);
        check("f_lit", dif.fractional, ef);
        check("dz_lit", dif.div_by_zero, edz);
        for (int t = 0; t < 6; t++) begin
            ce = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        ce = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_d1, t_g0;
        logic [2:0] gexp[5];
        gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

        ce = 1'b1;
        dif.req = 3'b000;
        dif.dividend_bus = '0;
        dif.divisor_bus = '0;
        apply_reset();

        single(0, 100, 200, 1'b0, 0, 128, 0);
        single(0, 255, 255, 1'b0, 1, 0, 0);
        single(0, 1, 3, 1'b0, 0, 85, 0);
        single(1, 37, 0, 1'b0, 1023, 255, 1);

        // Contention straight out of reset
        apply_reset();
        set_ops(0, 300, 600);
        set_ops(1, 512, 256);
        set_ops(2, 1023, 1);
        glog.delete();
        log_en = 1'b1;
        dif.req = 3'b111;
        for (int t = 0; t < 300 && glog.size() < 5; t++) tick();
        log_en = 1'b0;
        dif.req = 3'b010;
        wait_for(1, 1);
        dif.req = 3'b000;
        tick(); tick();
        check("grant_count", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++) check("grant_order", glog[k], gexp[k]);
        check("c0_f", rf[0], 128);
        check("c0_q", rq[0], 0);
        check("c1_q", rq[1], 2);
        check("c2_q", rq[2], 1023);

        single(0, 100, 200, 1'b1, 0, 128, 0);

        // Reset seven steps into a req2 division
        set_ops(2, 1000, 7);
        dif.req[2] = 1'b1;
        wait_for(0, 2);
        for (int t = 0; t < 7; t++) tick();
        rst = 1'b1;
        model_reset();
        #1;
        check("abort_q", dif.quotient, 0);
        compare_all();
        @(posedge clk); #1;
        check("abort_done", dif.done, 0);
        rst = 1'b0;
        wait_for(1, 2);
        dif.req[2] = 1'b0;
        check("rerun_q", dif.quotient, 142);
        check("rerun_f", dif.fractional, 219);
        tick(); tick();

        // Late req0 during a req1 division; bus0 changes before its grant
        set_ops(1, 500, 3);
        dif.req[1] = 1'b1;
        wait_for(0, 1);
        for (int t = 0; t < 5; t++) tick();
        set_ops(0, 11, 13);
        dif.req[0] = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        set_ops(0, 900, 700);
        wait_for(1, 1);
        t_d1 = cyc;
        dif.req[1] = 1'b0;
        wait_for(0, 0);
        t_g0 = cyc;
        set_ops(0, 5, 5);
        wait_for(1, 0);
        dif.req[0] = 1'b0;
        check("late_gap", t_g0 - t_d1, 2);
        check("late_q", dif.quotient, 1);
        check("late_f", dif.fractional, 73);
        tick(); tick();

        // Random traffic: random ce, operands churn every cycle, req drops on done
        for (int t = 0; t < 2500; t++) begin
            ce = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                set_ops(i, $urandom_range(0, 1023),
                        ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1023));
                if (!dif.req[i] && $urandom_range(0, 3) == 0) dif.req[i] = 1'b1;
            end
            tick();
            for (int i = 0; i < 3; i++)
                if (dif.done[i]) dif.req[i] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
